// File: rtl/door_input_conditioner.sv
// Conditions the garage-door button and limit-switch contacts: two-flop sync, per-channel
// debounce, a one-shot press pulse and a registered both-limits fault flag.

module door_input_conditioner_ch #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic Clock,
    input  logic Reset,
    input  logic raw_i,
    output logic deb_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             ff1_q, ff2_q;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any sample agreeing with the accepted level drops the count back to zero.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (ff2_q != deb_q) begin
            if (cnt_q == CNT_MAX) begin
                deb_d = ff2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
            cnt_q <= '0;
            deb_q <= 1'b0;
        end else begin
            ff1_q <= raw_i;
            ff2_q <= ff1_q;
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign deb_o = deb_q;
endmodule

module door_input_conditioner #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic Clock,
    input  logic Reset,
    input  logic ButtonRaw,
    input  logic UpperRaw,
    input  logic LowerRaw,
    output logic Button,
    output logic UpperLS,
    output logic LowerLS,
    output logic FaultLS
);
    localparam int NUM_CH = 3;
    localparam int CH_BTN = 0;
    localparam int CH_UP  = 1;
    localparam int CH_LO  = 2;

    typedef enum logic {IDLE, ARMED} state_e;

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] deb;
    state_e            state_q, state_d;
    logic              button_q, button_d;
    logic              fault_q, fault_d;

    assign raw = {LowerRaw, UpperRaw, ButtonRaw};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        door_input_conditioner_ch #(
            .DB_CYCLES(DB_CYCLES),
            .CNT_W    (CNT_W)
        ) u_ch (
            .Clock(Clock),
            .Reset(Reset),
            .raw_i(raw[g]),
            .deb_o(deb[g])
        );
    end

    // ARMED holds off further pulses until a debounced release is seen.
    always_comb begin
        state_d  = state_q;
        button_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (deb[CH_BTN]) begin
                    button_d = 1'b1;
                    state_d  = ARMED;
                end
            end
            ARMED: begin
                if (!deb[CH_BTN]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign fault_d = deb[CH_UP] & deb[CH_LO];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            button_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            button_q <= button_d;
            fault_q  <= fault_d;
        end
    end

    assign Button  = button_q;
    assign UpperLS = deb[CH_UP];
    assign LowerLS = deb[CH_LO];
    assign FaultLS = fault_q;
endmodule

// File: tb/tb_door_input_conditioner.sv
// Bench for door_input_conditioner with DB_CYCLES=4: expected Button pulse cycles are queued
// as stimulus is driven; limit levels are predicted from their change times.

module tb_door_input_conditioner;
    localparam int BIG = 1 << 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_raw = 1'b0, up_raw = 1'b0, lo_raw = 1'b0;
    logic button, upper_ls, lower_ls, fault_ls;

    int cyc = 0;
    int passed = 0;
    int total = 0;
    int bq[$];

    door_input_conditioner #(.DB_CYCLES(4), .CNT_W(3)) dut (
        .Clock(clk), .Reset(rst),
        .ButtonRaw(btn_raw), .UpperRaw(up_raw), .LowerRaw(lo_raw),
        .Button(button), .UpperLS(upper_ls), .LowerLS(lower_ls), .FaultLS(fault_ls)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({button, upper_ls, lower_ls, fault_ls} !== 4'b0000)
                $display("FAIL reset.outputs cyc=%0d got %b want 0000", cyc,
                         {button, upper_ls, lower_ls, fault_ls});
            else passed++;
        end
        rst = 1'b0;
    endtask

    task automatic test_clean_press();
        logic exp_b;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            exp_b = (bq.size() > 0 && bq[0] == cyc);
            if (exp_b) void'(bq.pop_front());
            total++;
            if (button !== exp_b) $display("FAIL clean_press.button cyc=%0d got %b want %b", cyc, button, exp_b);
            else passed++;
            if (i == 0) begin btn_raw = 1'b1; bq.push_back(cyc + 7); end
            if (i == 21) btn_raw = 1'b0;
        end
        total++;
        if (bq.size() != 0) $display("FAIL clean_press.missing got %0d pending want 0", bq.size());
        else passed++;
        bq.delete();
    endtask

    task automatic test_bounce();
        logic exp_b;
        logic pat[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            exp_b = (bq.size() > 0 && bq[0] == cyc);
            if (exp_b) void'(bq.pop_front());
            total++;
            if (button !== exp_b) $display("FAIL bounce.button cyc=%0d got %b want %b", cyc, button, exp_b);
            else passed++;
            if (i < 5) btn_raw = pat[i];
            if (i == 4) bq.push_back(cyc + 7);
            if (i == 20) btn_raw = 1'b0;
        end
        total++;
        if (bq.size() != 0) $display("FAIL bounce.missing got %0d pending want 0", bq.size());
        else passed++;
        bq.delete();
    endtask

    task automatic test_glitch();
        int up_r = BIG, up_f = BIG;
        logic exp_up;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            exp_up = (cyc >= up_r && cyc < up_f);
            total++;
            if (upper_ls !== exp_up) $display("FAIL glitch.upper_ls cyc=%0d got %b want %b", cyc, upper_ls, exp_up);
            else passed++;
            total++;
            if ({button, lower_ls, fault_ls} !== 3'b000)
                $display("FAIL glitch.others cyc=%0d got %b want 000", cyc, {button, lower_ls, fault_ls});
            else passed++;
            if (i == 0) up_raw = 1'b1;
            if (i == 3) up_raw = 1'b0;
            if (i == 14) begin up_raw = 1'b1; up_r = cyc + 6; end
            if (i == 18) begin up_raw = 1'b0; up_f = cyc + 6; end
        end
    endtask

    task automatic test_repress();
        logic exp_b;
        for (int i = 0; i < 95; i++) begin
            @(negedge clk);
            exp_b = (bq.size() > 0 && bq[0] == cyc);
            if (exp_b) void'(bq.pop_front());
            total++;
            if (button !== exp_b) $display("FAIL repress.button cyc=%0d got %b want %b", cyc, button, exp_b);
            else passed++;
            case (i)
                0, 20, 49: begin btn_raw = 1'b1; bq.push_back(cyc + 7); end
                10, 35, 61, 80: btn_raw = 1'b0;
                64: btn_raw = 1'b1;
                default: ;
            endcase
        end
        total++;
        if (bq.size() != 0) $display("FAIL repress.missing got %0d pending want 0", bq.size());
        else passed++;
        bq.delete();
    endtask

    task automatic test_fault();
        int up_r = BIG, up_f = BIG, lo_r = BIG, lo_f = BIG;
        logic exp_up, exp_lo, exp_f;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            exp_up = (cyc >= up_r && cyc < up_f);
            exp_lo = (cyc >= lo_r && cyc < lo_f);
            exp_f  = (cyc >= lo_r + 1 && cyc < lo_f + 1);
            total++;
            if ({upper_ls, lower_ls, fault_ls} !== {exp_up, exp_lo, exp_f})
                $display("FAIL fault.levels cyc=%0d got %b want %b", cyc,
                         {upper_ls, lower_ls, fault_ls}, {exp_up, exp_lo, exp_f});
            else passed++;
            total++;
            if (button !== 1'b0) $display("FAIL fault.button cyc=%0d got %b want 0", cyc, button);
            else passed++;
            if (i == 0)  begin up_raw = 1'b1; up_r = cyc + 6; end
            if (i == 3)  begin lo_raw = 1'b1; lo_r = cyc + 6; end
            if (i == 20) begin lo_raw = 1'b0; lo_f = cyc + 6; end
            if (i == 30) begin up_raw = 1'b0; up_f = cyc + 6; end
        end
    endtask

    task automatic test_reset_mid();
        int ls_r = BIG, ls_f = BIG, f_r = BIG, f_f = BIG;
        logic exp_b, exp_ls, exp_f;
        for (int i = 0; i < 46; i++) begin
            @(negedge clk);
            exp_b  = (bq.size() > 0 && bq[0] == cyc);
            if (exp_b) void'(bq.pop_front());
            exp_ls = (cyc >= ls_r && cyc < ls_f);
            exp_f  = (cyc >= f_r && cyc < f_f);
            total++;
            if ({button, upper_ls, lower_ls, fault_ls} !== {exp_b, exp_ls, exp_ls, exp_f})
                $display("FAIL reset_mid.outputs cyc=%0d got %b want %b", cyc,
                         {button, upper_ls, lower_ls, fault_ls}, {exp_b, exp_ls, exp_ls, exp_f});
            else passed++;
            if (i == 0) begin
                up_raw = 1'b1; lo_raw = 1'b1;
                ls_r = cyc + 6; f_r = cyc + 7;
            end
            if (i == 8) btn_raw = 1'b1;
            if (i == 11) begin rst = 1'b1; ls_f = cyc + 1; f_f = cyc + 1; end
            if (i == 13) begin
                rst = 1'b0;
                ls_r = cyc + 6; ls_f = BIG;
                f_r = cyc + 7;  f_f = BIG;
                bq.push_back(cyc + 7);
            end
            if (i == 30) begin
                btn_raw = 1'b0; up_raw = 1'b0; lo_raw = 1'b0;
                ls_f = cyc + 6; f_f = cyc + 7;
            end
        end
        total++;
        if (bq.size() != 0) $display("FAIL reset_mid.missing got %0d pending want 0", bq.size());
        else passed++;
        bq.delete();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_repress();
        test_fault();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
